// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note-to-voice allocator with age-based stealing (optional VOICE_ALLOC_SUSTAIN_EN adds a sustain pedal)
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ev_valid,
    output logic                    ev_ready,
    input  logic                    ev_on,
    input  logic [7:0]              ev_note,
`ifdef VOICE_ALLOC_SUSTAIN_EN
    input  logic                    sustain,
`endif
    output logic [NUM_VOICES*8-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES-1:0]   voice_retrig,
    output logic                    busy
);
    localparam int IW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx;
    logic            lat_on;
    logic [7:0]      lat_note;
    logic [AGE_W-1:0] age [NUM_VOICES];
    logic            match_found, free_found;
    logic [IW-1:0]   match_idx, free_idx, old_idx, tgt;
    logic [AGE_W-1:0] old_age, cur_age;
    logic [7:0]      cur_note;
    logic            cur_gate, first, accept, pend;
    logic [NUM_VOICES-1:0] held;

    // State register; reset aborts any event in flight
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: a pending sustain release blocks new events for one IDLE cycle
    always_comb begin
        accept   = state == IDLE && ev_valid && !pend;
        state_nx = state == IDLE ? (accept ? SCAN : IDLE)
                 : state == SCAN ? (idx == IW'(NUM_VOICES - 1) ? APPLY : SCAN)
                 : IDLE;
    end

    // FSM outputs
    always_comb begin
        ev_ready = state == IDLE && !pend && !RESET;
        busy     = state != IDLE;
    end

    // Voice under examination this SCAN cycle and the note-on target chosen from the scan results
    always_comb begin
        cur_note = voice_note[8*idx +: 8];
        cur_gate = voice_gate[idx];
        cur_age  = age[idx];
        first    = idx == '0;
        tgt      = match_found ? match_idx : free_found ? free_idx : old_idx;
    end

`ifdef VOICE_ALLOC_SUSTAIN_EN
    logic sus_q;

    // Sustain falling-edge detector; a new edge wins over the IDLE release clearing the flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sus_q <= 1'b0;
            pend  <= 1'b0;
        end else begin
            sus_q <= sustain;
            if (sus_q && !sustain) pend <= 1'b1;
            else if (state == IDLE) pend <= 1'b0;
        end
    end
`else
    assign pend = 1'b0;
`endif

    // Event latch, serial scan tracking and the single-cycle apply of voice state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx          <= '0;
            lat_on       <= 1'b0;
            lat_note     <= '0;
            match_found  <= 1'b0;
            free_found   <= 1'b0;
            match_idx    <= '0;
            free_idx     <= '0;
            old_idx      <= '0;
            old_age      <= '0;
            voice_note   <= '0;
            voice_gate   <= '0;
            voice_retrig <= '0;
            held         <= '0;
            for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
        end else begin
            voice_retrig <= '0;
            if (accept) begin
                lat_on   <= ev_on;
                lat_note <= ev_note;
                idx      <= '0;
            end
            if (state == SCAN) begin
                idx <= idx + 1'b1;
                if (cur_gate && cur_note == lat_note && (first || !match_found)) begin
                    match_found <= 1'b1;
                    match_idx   <= idx;
                end else if (first) begin
                    match_found <= 1'b0;
                end
                if (!cur_gate && (first || !free_found)) begin
                    free_found <= 1'b1;
                    free_idx   <= idx;
                end else if (first) begin
                    free_found <= 1'b0;
                end
                if (first || cur_age > old_age) begin
                    old_idx <= idx;
                    old_age <= cur_age;
                end
            end
            if (state == APPLY && !lat_note[7]) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (lat_on) begin
                        if (IW'(i) == tgt) begin
                            voice_note[8*i +: 8] <= lat_note;
                            voice_gate[i]        <= 1'b1;
                            voice_retrig[i]      <= 1'b1;
                            held[i]              <= 1'b0;
                            age[i]               <= '0;
                        end else if (age[i] != '1) begin
                            age[i] <= age[i] + 1'b1;
                        end
                    end else if (voice_gate[i] && voice_note[8*i +: 8] == lat_note) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
                        if (sustain) begin
                            held[i] <= 1'b1;
                        end else begin
                            voice_gate[i] <= 1'b0;
                            held[i]       <= 1'b0;
                        end
`else
                        voice_gate[i] <= 1'b0;
`endif
                    end
                end
            end
            if (state == IDLE && pend) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (held[i]) begin
                        voice_gate[i] <= 1'b0;
                        held[i]       <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: randomized self-checking bench for voice_allocator against a rule-level voice model (VOICE_ALLOC_SUSTAIN_EN adds the sustain scenario)
module tb_voice_allocator;
    localparam int NV = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          ev_valid = 1'b0;
    logic          ev_ready;
    logic          ev_on = 1'b0;
    logic [7:0]    ev_note = '0;
    logic [NV*8-1:0] voice_note;
    logic [NV-1:0] voice_gate;
    logic [NV-1:0] voice_retrig;
    logic          busy;
    logic          sus_tb = 1'b0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    logic          sustain;
    assign sustain = sus_tb;
`endif

    int errors = 0;
    int checks = 0;

    int m_note [NV];
    bit m_gate [NV];
    int m_age  [NV];
    bit m_held [NV];
    logic [NV-1:0] m_retrig;

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_on(ev_on),
        .ev_note(ev_note),
`ifdef VOICE_ALLOC_SUSTAIN_EN
        .sustain(sustain),
`endif
        .voice_note(voice_note),
        .voice_gate(voice_gate),
        .voice_retrig(voice_retrig),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = 0;
            m_gate[i] = 0;
            m_age[i]  = 0;
            m_held[i] = 0;
        end
        m_retrig = '0;
    endfunction

    // Voice choice from the allocation rules: existing sounding note, else first free, else oldest
    function automatic void model_apply(input bit on, input int n);
        int t;
        int best;
        m_retrig = '0;
        if (n > 127) return;
        if (on) begin
            t = -1;
            for (int i = 0; i < NV; i++) if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
            for (int i = 0; i < NV; i++) if (t < 0 && !m_gate[i]) t = i;
            if (t < 0) begin
                best = -1;
                for (int i = 0; i < NV; i++) if (m_age[i] > best) begin best = m_age[i]; t = i; end
            end
            for (int i = 0; i < NV; i++) begin
                if (i == t) begin
                    m_note[i] = n;
                    m_gate[i] = 1;
                    m_age[i]  = 0;
                    m_held[i] = 0;
                end else begin
                    m_age[i] = m_age[i] < 255 ? m_age[i] + 1 : 255;
                end
            end
            m_retrig[t] = 1'b1;
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (m_gate[i] && m_note[i] == n) begin
                    if (sus_tb) m_held[i] = 1;
                    else m_gate[i] = 0;
                end
            end
        end
    endfunction

    function automatic logic [NV*8-1:0] exp_notes();
        logic [NV*8-1:0] v;
        for (int i = 0; i < NV; i++) v[i*8 +: 8] = m_note[i][7:0];
        return v;
    endfunction

    function automatic logic [NV-1:0] exp_gates();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_gate[i];
        return v;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        ev_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        model_reset();
    endtask

    // Raise the event (held while ev_ready is low) and complete one handshake; returns at the negedge of T+1
    task automatic handshake(input bit on, input logic [7:0] n);
        int k = 0;
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = n;
        while (!ev_ready && k < 20) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_wait ev_ready=%b required=1 after %0d cycles", ev_ready, k);
        end
        @(posedge CLK);
        @(negedge CLK);
        ev_valid = 1'b0;
    endtask

    // From the negedge of T+1: check the busy window, then the results in cycle T+NV+2
    task automatic check_event(input bit on, input int n, input string tag);
        checks++;
        if (voice_retrig !== '0) begin
            errors++;
            $display("FAIL %s retrig_after_handshake got=%b required=0", tag, voice_retrig);
        end
        repeat (NV) @(negedge CLK);
        checks++;
        if (ev_ready !== 1'b0 || busy !== 1'b1 || voice_retrig !== '0) begin
            errors++;
            $display("FAIL %s apply_cycle ready=%b busy=%b retrig=%b required ready=0 busy=1 retrig=0", tag, ev_ready, busy, voice_retrig);
        end
        @(negedge CLK);
        model_apply(on, n);
        checks++;
        if (voice_note !== exp_notes() || voice_gate !== exp_gates() || voice_retrig !== m_retrig || ev_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s result notes=%h gate=%b retrig=%b ready=%b busy=%b required notes=%h gate=%b retrig=%b ready=1 busy=0",
                     tag, voice_note, voice_gate, voice_retrig, ev_ready, busy, exp_notes(), exp_gates(), m_retrig);
        end
    endtask

    task automatic do_event(input bit on, input int n, input string tag);
        handshake(on, 8'(n));
        check_event(on, n, tag);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (ev_ready !== 1'b0 || busy !== 1'b0 || voice_note !== '0 || voice_gate !== '0 || voice_retrig !== '0) begin
            errors++;
            $display("FAIL reset_hold ready=%b busy=%b notes=%h gate=%b retrig=%b required all 0", ev_ready, busy, voice_note, voice_gate, voice_retrig);
        end
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (ev_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release ready=%b busy=%b required ready=1 busy=0", ev_ready, busy);
        end
        model_reset();
    endtask

    task automatic test_first_note();
        do_reset();
        do_event(1, 60, "first_note");
        checks++;
        if (voice_note[7:0] !== 8'd60 || voice_gate !== 4'b0001 || voice_retrig !== 4'b0001) begin
            errors++;
            $display("FAIL first_note_const note0=%0d gate=%b retrig=%b required 60 0001 0001", voice_note[7:0], voice_gate, voice_retrig);
        end
        @(negedge CLK);
        checks++;
        if (voice_retrig !== '0) begin
            errors++;
            $display("FAIL first_note_pulse_width retrig=%b required=0", voice_retrig);
        end
    endtask

    task automatic test_steal();
        do_reset();
        do_event(1, 60, "fill0");
        do_event(1, 62, "fill1");
        do_event(1, 64, "fill2");
        do_event(1, 65, "fill3");
        do_event(1, 67, "steal");
        checks++;
        if (voice_note !== {8'd65, 8'd64, 8'd62, 8'd67} || voice_gate !== 4'b1111 || voice_retrig !== 4'b0001) begin
            errors++;
            $display("FAIL steal_const notes=%h gate=%b retrig=%b required 41403e43 1111 0001", voice_note, voice_gate, voice_retrig);
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        do_event(1, 60, "retrig_a");
        do_event(1, 60, "retrig_b");
        checks++;
        if (voice_gate !== 4'b0001 || voice_retrig !== 4'b0001 || voice_note[15:8] !== 8'd0) begin
            errors++;
            $display("FAIL retrigger_const gate=%b retrig=%b note1=%0d required 0001 0001 0", voice_gate, voice_retrig, voice_note[15:8]);
        end
    endtask

    task automatic test_note_off();
        do_reset();
        do_event(1, 60, "off_on");
        do_event(0, 60, "off_60");
        checks++;
        if (voice_gate !== 4'b0000 || voice_note[7:0] !== 8'd60 || voice_retrig !== '0) begin
            errors++;
            $display("FAIL note_off_const gate=%b note0=%0d retrig=%b required 0000 60 0000", voice_gate, voice_note[7:0], voice_retrig);
        end
        do_event(1, 62, "off_on62");
        do_event(0, 61, "off_nomatch");
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_event(1, 50, "mid_pre");
        handshake(1, 8'd72);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (voice_note !== '0 || voice_gate !== '0 || voice_retrig !== '0 || busy !== 1'b0 || ev_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid notes=%h gate=%b retrig=%b busy=%b ready=%b required all 0", voice_note, voice_gate, voice_retrig, busy, ev_ready);
        end
        RESET = 1'b0;
        model_reset();
        @(negedge CLK);
        checks++;
        if (ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready ready=%b required=1", ev_ready);
        end
        repeat (NV + 3) @(negedge CLK);
        checks++;
        if (voice_note !== '0 || voice_gate !== '0) begin
            errors++;
            $display("FAIL reset_mid_abort notes=%h gate=%b required 0 0", voice_note, voice_gate);
        end
    endtask

    task automatic test_invalid_note();
        do_reset();
        do_event(1, 64, "inv_pre");
        do_event(1, 200, "inv_200");
        do_event(0, 64 + 128, "inv_off");
        do_event(1, 66, "inv_post");
    endtask

    task automatic test_back_to_back();
        do_reset();
        handshake(1, 8'd70);
        handshake(1, 8'd71);
        model_apply(1, 70);
        check_event(1, 71, "b2b");
    endtask

    task automatic test_random();
        int n;
        bit on;
        do_reset();
        for (int k = 0; k < 80; k++) begin
            on = $urandom_range(0, 99) < 65;
            n  = ($urandom_range(0, 19) == 0) ? $urandom_range(128, 255) : $urandom_range(40, 47);
            do_event(on, n, "random");
        end
    endtask

`ifdef VOICE_ALLOC_SUSTAIN_EN
    task automatic test_sustain();
        do_reset();
        sus_tb = 1'b1;
        do_event(1, 60, "sus_on");
        do_event(0, 60, "sus_off");
        checks++;
        if (voice_gate !== 4'b0001) begin
            errors++;
            $display("FAIL sustain_hold gate=%b required 0001", voice_gate);
        end
        sus_tb = 1'b0;
        @(negedge CLK);
        checks++;
        if (ev_ready !== 1'b0 || voice_gate !== 4'b0001) begin
            errors++;
            $display("FAIL sustain_release_cycle ready=%b gate=%b required ready=0 gate=0001", ev_ready, voice_gate);
        end
        @(negedge CLK);
        for (int i = 0; i < NV; i++) if (m_held[i]) begin m_gate[i] = 0; m_held[i] = 0; end
        checks++;
        if (ev_ready !== 1'b1 || voice_gate !== exp_gates()) begin
            errors++;
            $display("FAIL sustain_released ready=%b gate=%b required ready=1 gate=%b", ev_ready, voice_gate, exp_gates());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_note();
        test_steal();
        test_retrigger();
        test_note_off();
        test_reset_mid();
        test_invalid_note();
        test_back_to_back();
        test_random();
`ifdef VOICE_ALLOC_SUSTAIN_EN
        test_sustain();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
